// File: rtl/adc_sample_sched_pkg.sv
// Shared types and sizing for the ADC sample scheduler.
package adc_sample_sched_pkg;

  localparam int unsigned N_REQ_DEF    = 3;
  localparam int unsigned PERIOD_W_DEF = 8;
  localparam int unsigned ADC_W        = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_SYNC,
    ST_CONV,
    ST_DELIVER
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant wins.
module rr_arbiter #(
  parameter int unsigned N = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c
);

  logic             found;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    sel         = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      sel = IDX_W'((32'(last_grant) + k) % N);
      if (!found && req[sel]) begin
        found       = 1'b1;
        grant_c     = '0;
        grant_c[sel] = 1'b1;
        grant_idx_c = sel;
      end
    end
  end

endmodule

// File: rtl/adc_sample_sched.sv
// Schedules conversions of a shared serial ADC receiver among N_REQ requesters
// plus an internal periodic trigger that rides on requester 0.
module adc_sample_sched
  import adc_sample_sched_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                sclk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    ack,
  input  logic                periodic_en,
  input  logic [PERIOD_W-1:0] period,
  input  logic                rx_done_tick,
  input  logic [ADC_W-1:0]    adc_dout,
  output logic                rx_en,
  output logic [N_REQ-1:0]    grant,
  output logic [ADC_W-1:0]    sample,
  output logic [N_REQ-1:0]    sample_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_q;
  logic [N_REQ-1:0]    req_eff_c;
  logic [N_REQ-1:0]    pick_c;
  logic [IDX_W-1:0]    pick_idx_c;
  logic [PERIOD_W-1:0] cnt_q;
  logic                per_pending;
  logic                per_tick_c;
  logic                ack_hit_c;
  logic                per_clr_c;

  // The periodic trigger requests on behalf of requester 0.
  assign req_eff_c  = req | N_REQ'(per_pending);
  assign ack_hit_c  = (state_q == ST_DELIVER) && (|(ack & grant));
  assign per_clr_c  = ack_hit_c && grant[0];
  assign per_tick_c = periodic_en && (cnt_q >= period);

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req_eff_c),
    .last_grant  (last_q),
    .grant_c     (pick_c),
    .grant_idx_c (pick_idx_c)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; the first tick in SYNC closes a partial frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (|req_eff_c)   state_d = ST_ARB;
      ST_ARB:                       state_d = ST_SYNC;
      ST_SYNC:    if (rx_done_tick) state_d = ST_CONV;
      ST_CONV:    if (rx_done_tick) state_d = ST_DELIVER;
      ST_DELIVER: if (ack_hit_c)    state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      rx_en        <= 1'b0;
      busy         <= 1'b0;
      grant        <= '0;
      last_q       <= IDX_W'(N_REQ - 1);
      sample       <= '0;
      sample_valid <= '0;
    end else begin
      rx_en <= (state_d == ST_SYNC) || (state_d == ST_CONV);
      busy  <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && state_d == ST_ARB) begin
        grant  <= pick_c;
        last_q <= pick_idx_c;
      end else if (state_d == ST_IDLE) begin
        grant <= '0;
      end
      if (state_q == ST_CONV && rx_done_tick) sample <= adc_dout;
      sample_valid <= (state_d == ST_DELIVER) ? grant : '0;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst)              cnt_q <= '0;
    else if (!periodic_en) cnt_q <= '0;
    else if (per_tick_c)  cnt_q <= '0;
    else                  cnt_q <= cnt_q + PERIOD_W'(1);
  end

  // A new trigger wins over a same-cycle clear and is not an overrun then.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      per_pending <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (per_tick_c)     per_pending <= 1'b1;
      else if (per_clr_c) per_pending <= 1'b0;
      if (per_tick_c && per_pending && !per_clr_c) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_sample_sched.sv
// Randomized and directed bench for adc_sample_sched with a behavioural model.
`timescale 1ns/1ps
module tb_adc_sample_sched;

  localparam int N  = 3;
  localparam int PW = 8;

  logic          sclk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, ack, grant, sample_valid;
  logic          periodic_en;
  logic [PW-1:0] period;
  logic          rx_done_tick;
  logic [11:0]   adc_dout, sample;
  logic          rx_en, busy, overrun;

  always #5 sclk = ~sclk;

  adc_sample_sched #(.N_REQ(N), .PERIOD_W(PW)) dut (
    .sclk(sclk), .rst(rst), .req(req), .ack(ack),
    .periodic_en(periodic_en), .period(period),
    .rx_done_tick(rx_done_tick), .adc_dout(adc_dout),
    .rx_en(rx_en), .grant(grant), .sample(sample),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 arb, 2 waiting first frame, 3 waiting data frame, 4 deliver.
  int          m_phase, m_owner, m_last, m_cnt;
  bit          m_pend, m_ovr;
  logic [11:0] m_sample;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    m_pend = 0; m_ovr = 0; m_sample = 12'h000;
  endtask

  task automatic model_step();
    bit tick, clr, found;
    logic [N-1:0] eff;
    int nph, idx;
    tick = periodic_en && (m_cnt >= int'(period));
    clr  = (m_phase == 4) && ack[m_owner] && (m_owner == 0);
    eff  = req;
    eff[0] = eff[0] | m_pend;
    nph = m_phase;
    case (m_phase)
      0: if (eff != 0) begin
           found = 0;
           for (int k = 1; k <= N; k++) begin
             idx = (m_last + k) % N;
             if (!found && eff[idx]) begin found = 1; m_owner = idx; end
           end
           m_last = m_owner;
           nph = 1;
         end
      1: nph = 2;
      2: if (rx_done_tick) nph = 3;
      3: if (rx_done_tick) begin m_sample = adc_dout; nph = 4; end
      4: if (ack[m_owner]) nph = 0;
      default: nph = 0;
    endcase
    if (tick && m_pend && !clr) m_ovr = 1;
    m_pend  = tick ? 1'b1 : (clr ? 1'b0 : m_pend);
    m_cnt   = !periodic_en ? 0 : (tick ? 0 : m_cnt + 1);
    m_phase = nph;
  endtask

  bit chk_en = 0;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge sclk) begin
    if (chk_en) begin
      chk("busy",         32'(busy),         32'(m_phase != 0));
      chk("rx_en",        32'(rx_en),        32'(m_phase == 2 || m_phase == 3));
      chk("grant",        32'(grant),        (m_phase != 0) ? 32'(1 << m_owner) : 32'd0);
      chk("sample_valid", 32'(sample_valid), (m_phase == 4) ? 32'(1 << m_owner) : 32'd0);
      chk("sample",       32'(sample),       32'(m_sample));
      chk("overrun",      32'(overrun),      32'(m_ovr));
      chk("onehot_grant", 32'($countones(grant) <= 1), 32'd1);
    end
  end

  // Stimulus state
  int          fc;
  bit          use_fixed, rand_mode, auto_ack;
  logic [11:0] fixed_dout;
  logic [N-1:0] ack_mask;

  // One clock: advance model with pre-edge inputs, then drive new inputs.
  task automatic cyc();
    @(posedge sclk);
    if (rst) model_reset(); else model_step();
    #1;
    if (rst) begin
      fc = 0; rx_done_tick = 0;
    end else begin
      fc = (fc == 16) ? 0 : fc + 1;
      rx_done_tick = (fc == 16);
      if (rx_done_tick) adc_dout = use_fixed ? fixed_dout : 12'($urandom);
    end
    if (rand_mode) begin
      req = N'($urandom);
      ack = N'($urandom);
      if ($urandom_range(0, 49) == 0) periodic_en = ~periodic_en;
    end else begin
      ack = auto_ack ? (sample_valid & ack_mask) : '0;
    end
  endtask

  task automatic do_reset();
    @(posedge sclk);
    #1;
    rst = 1'b1;
    model_reset();
    cyc();
    rst = 1'b0;
    fc = $urandom_range(0, 16);
  endtask

  task automatic wait_sv(output int n);
    n = 0;
    while (sample_valid == '0 && n < 60) begin cyc(); n++; end
    chk("sv_timeout", 32'(sample_valid != '0), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 80) begin cyc(); n++; end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n, last_rise, rises;
    logic [N-1:0] prev_g;
    logic [N-1:0] exp_ord [4];
    exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100; exp_ord[3] = 3'b001;

    rst = 1'b1; req = '0; ack = '0; periodic_en = 0; period = '0;
    rx_done_tick = 0; adc_dout = '0; fc = 0;
    use_fixed = 0; rand_mode = 0; auto_ack = 0; fixed_dout = '0; ack_mask = '0;
    model_reset();
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_rx_en", 32'(rx_en), 32'd0);
    chk("rst_sv",    32'(sample_valid), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    @(posedge sclk); #1;
    rst = 1'b0;
    fc = $urandom_range(0, 16);
    chk_en = 1;

    // Single request from requester 1
    use_fixed = 1; fixed_dout = 12'hA5C; auto_ack = 1; ack_mask = 3'b010;
    req = 3'b010;
    wait_sv(n);
    chk("lat_le_35", 32'((n - 1) <= 35), 32'd1);
    chk("single_grant", 32'(grant), 32'h2);
    chk("single_sample", 32'(sample), 32'hA5C);
    chk("single_sv", 32'(sample_valid), 32'h2);
    req = '0;
    cyc();
    chk("single_idle", 32'(busy), 32'd0);

    // Round-robin under contention from reset
    do_reset();
    use_fixed = 0; ack_mask = 3'b111; req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_sv(n);
      chk("rr_order", 32'(grant), 32'(exp_ord[i]));
      cyc();
    end
    req = '0;
    wait_idle();

    // Ack stall: result must hold with receiver disabled
    use_fixed = 1; fixed_dout = 12'h3C7; auto_ack = 0; req = 3'b001;
    wait_sv(n);
    req = '0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      chk("stall_sample", 32'(sample), 32'h3C7);
      chk("stall_sv", 32'(sample_valid), 32'h1);
      chk("stall_rx_en", 32'(rx_en), 32'd0);
    end
    auto_ack = 1; ack_mask = 3'b111;
    wait_idle();

    // Periodic trigger every 100 cycles
    use_fixed = 0; period = PW'(99); periodic_en = 1;
    last_rise = -1; rises = 0; prev_g = '0;
    for (int t = 0; t < 450; t++) begin
      cyc();
      if (grant != '0 && prev_g == '0) begin
        chk("per_grant", 32'(grant), 32'h1);
        if (last_rise >= 0) chk("per_spacing", 32'(t - last_rise), 32'd100);
        last_rise = t; rises++;
      end
      prev_g = grant;
    end
    chk("per_rises", 32'(rises >= 4), 32'd1);
    chk("per_no_ovr", 32'(overrun), 32'd0);
    periodic_en = 0;
    wait_idle();

    // Overrun with ack[0] withheld
    do_reset();
    ack_mask = 3'b110; period = PW'(9); periodic_en = 1;
    repeat (15) cyc();
    chk("ovr_after_1st", 32'(overrun), 32'd0);
    repeat (10) cyc();
    chk("ovr_after_2nd", 32'(overrun), 32'd1);
    repeat (100) cyc();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    periodic_en = 0;
    do_reset();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // period = 0 fires every cycle
    ack_mask = 3'b111; period = '0; periodic_en = 1;
    repeat (3) cyc();
    chk("p0_ovr", 32'(overrun), 32'd1);
    periodic_en = 0;
    do_reset();

    // Reset while converting
    req = 3'b100; auto_ack = 1;
    n = 0;
    while (m_phase != 3 && n < 60) begin cyc(); n++; end
    chk("reach_conv", 32'(m_phase), 32'd3);
    req = '0;
    @(posedge sclk); #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rc_grant", 32'(grant), 32'd0);
    chk("rc_rx_en", 32'(rx_en), 32'd0);
    chk("rc_busy",  32'(busy),  32'd0);
    chk("rc_sv",    32'(sample_valid), 32'd0);
    chk("rc_sample", 32'(sample), 32'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      chk("rc_no_sv", 32'(sample_valid), 32'd0);
    end

    // Randomized traffic
    period = PW'($urandom_range(20, 60)); periodic_en = 1;
    rand_mode = 1;
    repeat (3000) cyc();
    period = '0;
    repeat (200) cyc();
    rand_mode = 0; req = '0; ack = '0; periodic_en = 0;
    repeat (2) cyc();
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
